gpio_apb_arbiter: RTL and testbench
===================================

GPIO_APB_ARBITER -- requirements
Module: gpio_apb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, address width on all ports.
REQ-002 Parameter DATA_W, default 32, data width on all ports.
REQ-003 Parameter TMO_CYC, default 16, maximum ACCESS cycles with s_pready low before forced completion; legal range 1-255.
REQ-004 One clock, PCLK; reset is asynchronous and active-low, PRESETn.
REQ-005 PCLK  in  1  clock.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 m0_psel, m0_penable, m0_pwrite  in  1 each  requester 0 APB control.
REQ-008 m0_paddr  in  ADDR_W; m0_pwdata  in  DATA_W  requester 0 address and write data.
REQ-009 m0_prdata  out  DATA_W; m0_pready, m0_pslverr  out  1 each  requester 0 response.
REQ-010 m1_* ports are identical to m0_* ports and serve requester 1.
REQ-011 s_psel, s_penable, s_pwrite  out  1 each  shared-slave APB control.
REQ-012 s_paddr  out  ADDR_W; s_pwdata  out  DATA_W  shared-slave address and write data.
REQ-013 s_prdata  in  DATA_W; s_pready, s_pslverr  in  1 each  shared-slave response.
REQ-014 tmo_pulse  out  1  one-cycle pulse per timed-out transfer.
REQ-015 tmo_count  out  8  saturating count of timeouts since reset.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, and all outputs SHALL be registered.
REQ-017 In IDLE, a request is mN_psel=1; if any request is present, the FSM SHALL grant one requester, capture its pwrite/paddr/pwdata, and move to SETUP.
REQ-018 Arbitration SHALL be round-robin: with both requesting, the grant goes to the requester not granted last; last-grant resets to 1, so m0 wins the first tie.
REQ-019 In SETUP, the block SHALL drive s_psel=1, s_penable=0 and the captured fields, then move to ACCESS.
REQ-020 In ACCESS, the block SHALL drive s_psel=1, s_penable=1 and hold the fields stable until s_pready=1 or timeout.
REQ-021 When s_pready=1 in ACCESS, the block SHALL register s_prdata and s_pslverr, deassert s_psel/s_penable next cycle, and move to RESP.
REQ-022 A cycle counter SHALL count ACCESS cycles; if TMO_CYC cycles elapse with s_pready=0, the block SHALL move to RESP with prdata=0, pslverr=1, tmo_pulse=1 for one cycle, and tmo_count+1 saturating at 255.
REQ-023 In RESP, only the granted requester SHALL see pready=1 for exactly one cycle with the registered prdata/pslverr, and the FSM SHALL then return to IDLE.
REQ-024 Outside its RESP cycle each mN_pready SHALL be 0, and its mN_prdata/mN_pslverr SHALL be 0.
REQ-025 Latency: request sampled in IDLE at cycle T, zero-wait slave -> SETUP T+1, ACCESS T+2, mN_pready=1 at T+3; the next grant can be sampled in IDLE at T+4.
REQ-026 A requester that drops psel after grant SHALL NOT abort the downstream transfer; it completes normally and the response is discarded.
REQ-027 A pending requester SHALL be served no later than the next transfer after the current one, which guarantees no starvation.
REQ-028 mN_penable SHALL NOT affect arbitration, only psel.

Reset
REQ-029 On PRESETn low, the FSM SHALL go to IDLE, last-grant to 1, counters to 0, and every output to 0, including s_psel, s_penable, all mN_pready, tmo_pulse and tmo_count.
REQ-030 Reset mid-transfer SHALL drop s_psel immediately (asynchronously), with no response delivered.

Verification
REQ-031 m0 write, addr 0x04, data 0xA5A5_0001, zero-wait slave -> s_psel at T+1, s_penable at T+2, m0_pready=1 at T+3, m0_pslverr=0.
REQ-032 m0 and m1 request together from reset -> m0 is served first, then m1; repeating the tie gives m0, m1 in alternation.
REQ-033 m1 read, addr 0x1C, slave holds s_pready low 3 cycles then returns 0x0000_0080 -> m1_prdata=0x0000_0080 one cycle after s_pready; m0_pready stays 0.
REQ-034 Slave never asserts s_pready, TMO_CYC=16 -> after 16 ACCESS cycles, m0_pslverr=1, prdata=0, tmo_pulse=1 and tmo_count=1; 300 timeouts -> tmo_count=255.
REQ-035 Slave returns s_pslverr=1 -> the granted requester sees pslverr=1; tmo_count is unchanged.
REQ-036 PRESETn asserted during ACCESS -> all outputs are 0 that cycle; after release, a new m1 request completes normally.

Source files
------------

// File: rtl/gpio_apb_arbiter.sv
// Two-requester APB arbiter in front of one shared APB slave. Round-robin grant,
// registered outputs, and a per-transfer ACCESS timeout that forces an error response.
module gpio_apb_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    input  logic              s_pslverr,
    output logic              tmo_pulse,
    output logic [7:0]        tmo_count
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_gnt;
    logic [7:0]        r_cnt;
    logic              r_s_psel, r_s_penable, r_s_pwrite;
    logic [ADDR_W-1:0] r_s_paddr;
    logic [DATA_W-1:0] r_s_pwdata;
    logic [DATA_W-1:0] r_m0_prdata, r_m1_prdata;
    logic              r_m0_pready, r_m1_pready, r_m0_pslverr, r_m1_pslverr;
    logic              r_tmo_pulse;
    logic [7:0]        r_tmo_count;

    logic              w_pick1, w_tmo, w_keep, w_err;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    // Requester penable plays no part in arbitration.
    assign w_unused = m0_penable ^ m1_penable;

    assign w_pick1 = m1_psel & (~m0_psel | ~r_last);
    assign w_tmo   = (r_cnt == 8'(TMO_CYC - 1));
    assign w_keep  = r_gnt ? m1_psel : m0_psel;
    assign w_rdata = s_pready ? s_prdata : '0;
    assign w_err   = s_pready ? s_pslverr : 1'b1;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_gnt        <= 1'b0;
            r_cnt        <= '0;
            r_s_psel     <= 1'b0;
            r_s_penable  <= 1'b0;
            r_s_pwrite   <= 1'b0;
            r_s_paddr    <= '0;
            r_s_pwdata   <= '0;
            r_m0_prdata  <= '0;
            r_m1_prdata  <= '0;
            r_m0_pready  <= 1'b0;
            r_m1_pready  <= 1'b0;
            r_m0_pslverr <= 1'b0;
            r_m1_pslverr <= 1'b0;
            r_tmo_pulse  <= 1'b0;
            r_tmo_count  <= '0;
        end else begin
            r_tmo_pulse  <= 1'b0;
            r_m0_pready  <= 1'b0;
            r_m1_pready  <= 1'b0;
            r_m0_prdata  <= '0;
            r_m1_prdata  <= '0;
            r_m0_pslverr <= 1'b0;
            r_m1_pslverr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (m0_psel || m1_psel) begin
                        r_gnt       <= w_pick1;
                        r_last      <= w_pick1;
                        r_s_pwrite  <= w_pick1 ? m1_pwrite : m0_pwrite;
                        r_s_paddr   <= w_pick1 ? m1_paddr  : m0_paddr;
                        r_s_pwdata  <= w_pick1 ? m1_pwdata : m0_pwdata;
                        r_s_psel    <= 1'b1;
                        r_s_penable <= 1'b0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_s_penable <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= ACCESS;
                end
                ACCESS: begin
                    if (s_pready || w_tmo) begin
                        r_s_psel    <= 1'b0;
                        r_s_penable <= 1'b0;
                        r_state     <= RESP;
                        // A requester that let go of psel gets no response.
                        if (w_keep && !r_gnt) begin
                            r_m0_pready  <= 1'b1;
                            r_m0_prdata  <= w_rdata;
                            r_m0_pslverr <= w_err;
                        end
                        if (w_keep && r_gnt) begin
                            r_m1_pready  <= 1'b1;
                            r_m1_prdata  <= w_rdata;
                            r_m1_pslverr <= w_err;
                        end
                        if (!s_pready) begin
                            r_tmo_pulse <= 1'b1;
                            if (r_tmo_count != 8'hFF) r_tmo_count <= r_tmo_count + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_psel     = r_s_psel;
    assign s_penable  = r_s_penable;
    assign s_pwrite   = r_s_pwrite;
    assign s_paddr    = r_s_paddr;
    assign s_pwdata   = r_s_pwdata;
    assign m0_prdata  = r_m0_prdata;
    assign m0_pready  = r_m0_pready;
    assign m0_pslverr = r_m0_pslverr;
    assign m1_prdata  = r_m1_prdata;
    assign m1_pready  = r_m1_pready;
    assign m1_pslverr = r_m1_pslverr;
    assign tmo_pulse  = r_tmo_pulse;
    assign tmo_count  = r_tmo_count;
endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed bench for gpio_apb_arbiter: vector table of single transfers plus
// hand-written round-robin, timeout, dropped-request and reset sequences.
module tb_gpio_apb_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        m0_psel = 0, m0_penable = 0, m0_pwrite = 0;
    logic [5:0]  m0_paddr = '0;
    logic [31:0] m0_pwdata = '0;
    logic [31:0] m0_prdata;
    logic        m0_pready, m0_pslverr;
    logic        m1_psel = 0, m1_penable = 0, m1_pwrite = 0;
    logic [5:0]  m1_paddr = '0;
    logic [31:0] m1_pwdata = '0;
    logic [31:0] m1_prdata;
    logic        m1_pready, m1_pslverr;
    logic        s_psel, s_penable, s_pwrite;
    logic [5:0]  s_paddr;
    logic [31:0] s_pwdata;
    logic [31:0] s_prdata = '0;
    logic        s_pready = 0, s_pslverr = 0;
    logic        tmo_pulse;
    logic [7:0]  tmo_count;

    int total = 0;
    int bad = 0;
    int exp_tmo = 0;

    always #5 PCLK = ~PCLK;

    gpio_apb_arbiter #(.ADDR_W(6), .DATA_W(32), .TMO_CYC(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
        .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
        .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .tmo_pulse(tmo_pulse), .tmo_count(tmo_count)
    );

    typedef struct {
        bit          m;
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_m(input bit m, input bit sel, input bit wr, input logic [5:0] a, input logic [31:0] d);
        if (m) begin
            m1_psel = sel; m1_penable = sel; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d;
        end else begin
            m0_psel = sel; m0_penable = sel; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d;
        end
    endtask

    task automatic run_vec(input vec_t v);
        set_m(v.m, 1'b1, v.wr, v.addr, v.wdata);
        step();
        chk("setup_psel", 32'(s_psel), 32'd1);
        chk("setup_penable", 32'(s_penable), 32'd0);
        chk("setup_paddr", 32'(s_paddr), 32'(v.addr));
        chk("setup_pwrite", 32'(s_pwrite), 32'(v.wr));
        chk("setup_pwdata", s_pwdata, v.wdata);
        step();
        chk("access_penable", 32'(s_penable), 32'd1);
        for (int i = 0; i < v.waits; i++) begin
            step();
            chk("wait_pready", {30'd0, m1_pready, m0_pready}, 32'd0);
        end
        s_pready = 1'b1; s_prdata = v.rdata; s_pslverr = v.err;
        step();
        chk("resp_pready", 32'(v.m ? m1_pready : m0_pready), 32'd1);
        chk("resp_other_pready", 32'(v.m ? m0_pready : m1_pready), 32'd0);
        chk("resp_prdata", v.m ? m1_prdata : m0_prdata, v.exp_rdata);
        chk("resp_pslverr", 32'(v.m ? m1_pslverr : m0_pslverr), 32'(v.exp_err));
        chk("resp_s_psel", 32'(s_psel), 32'd0);
        chk("resp_tmo_count", 32'(tmo_count), 32'(exp_tmo));
        s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
        set_m(v.m, 1'b0, 1'b0, '0, '0);
        step();
        chk("idle_pready", {30'd0, m1_pready, m0_pready}, 32'd0);
        chk("idle_prdata", v.m ? m1_prdata : m0_prdata, 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        vecs[0] = '{1'b0, 1'b1, 6'h04, 32'hA5A5_0001, 0,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 6'h1C, 32'h0000_0000, 3,  32'h0000_0080, 1'b0, 32'h0000_0080, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 6'h3F, 32'h0000_0000, 1,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 6'h00, 32'h1234_0000, 0,  32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 6'h2A, 32'h0000_0000, 15, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};

        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_s_psel", 32'(s_psel), 32'd0);
        chk("rst_s_penable", 32'(s_penable), 32'd0);
        chk("rst_pready", {30'd0, m1_pready, m0_pready}, 32'd0);
        chk("rst_tmo_pulse", 32'(tmo_pulse), 32'd0);
        chk("rst_tmo_count", 32'(tmo_count), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Tie from reset: m0 first, then strict alternation.
        set_m(1'b0, 1'b1, 1'b0, 6'h10, '0);
        set_m(1'b1, 1'b1, 1'b0, 6'h20, '0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_grant_addr", 32'(s_paddr), (k % 2 == 1) ? 32'h20 : 32'h10);
            s_pready = 1'b1;
            step();
            step();
            chk("rr_m0_pready", 32'(m0_pready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_m1_pready", 32'(m1_pready), (k % 2 == 1) ? 32'd1 : 32'd0);
            s_pready = 1'b0;
            if (k == 3) begin
                set_m(1'b0, 1'b0, 1'b0, '0, '0);
                set_m(1'b1, 1'b0, 1'b0, '0, '0);
            end
            step();
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Slave never answers: forced error after 16 ACCESS cycles.
        set_m(1'b0, 1'b1, 1'b0, 6'h08, '0);
        step();
        step();
        repeat (15) step();
        chk("tmo_pre_pready", 32'(m0_pready), 32'd0);
        chk("tmo_pre_penable", 32'(s_penable), 32'd1);
        step();
        exp_tmo = 1;
        chk("tmo_pready", 32'(m0_pready), 32'd1);
        chk("tmo_pslverr", 32'(m0_pslverr), 32'd1);
        chk("tmo_prdata", m0_prdata, 32'd0);
        chk("tmo_pulse", 32'(tmo_pulse), 32'd1);
        chk("tmo_count1", 32'(tmo_count), 32'(exp_tmo));
        step();
        chk("tmo_pulse_one_cycle", 32'(tmo_pulse), 32'd0);
        n = 1;
        cyc = 0;
        while (n < 300 && cyc < 20000) begin
            step();
            cyc++;
            if (tmo_pulse) n++;
        end
        chk("tmo_events", 32'(n), 32'd300);
        set_m(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("tmo_count_sat", 32'(tmo_count), 32'd255);

        // Requester drops psel after grant: transfer completes, response discarded.
        set_m(1'b0, 1'b1, 1'b0, 6'h11, '0);
        step();
        set_m(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("drop_access_psel", 32'(s_psel), 32'd1);
        s_pready = 1'b1; s_prdata = 32'h55;
        step();
        chk("drop_no_pready", {30'd0, m1_pready, m0_pready}, 32'd0);
        chk("drop_s_psel", 32'(s_psel), 32'd0);
        s_pready = 1'b0; s_prdata = '0;
        step();
        step();
        chk("drop_no_regrant", 32'(s_psel), 32'd0);

        // Asynchronous reset in ACCESS.
        set_m(1'b0, 1'b1, 1'b1, 6'h30, 32'hCAFE_0000);
        step();
        step();
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_s_psel", 32'(s_psel), 32'd0);
        chk("arst_s_penable", 32'(s_penable), 32'd0);
        chk("arst_tmo_count", 32'(tmo_count), 32'd0);
        chk("arst_pready", {30'd0, m1_pready, m0_pready}, 32'd0);
        set_m(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        exp_tmo = 0;
        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
